// File: rtl/ipc_doorbell_master.sv
// ipc_doorbell_master
// AHB-Lite write-only initiator that raises and clears APU soft IRQs.
// Hardware event sources post per-cycle set/clear requests. The requests are
// merged into two pending vectors. Each non-empty vector is then written as
// one 32-bit word to SOFTIRQ_CLR or SOFTIRQ_SET. A pending clear is always
// issued before a pending set.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_set/req_clr per-cycle set/clear requests, one bit per soft IRQ
//   busy            something pending or a transfer in flight
//   err             one-cycle pulse after a write completed with an error
//   ahblm_*         AHB-Lite master port (IDLE/NONSEQ, single word writes)
module ipc_doorbell_master #(
    parameter int                N_IRQ    = 2,
    parameter int                W_ADDR   = 16,
    parameter logic [W_ADDR-1:0] ADDR_SET = 16'h0000,
    parameter logic [W_ADDR-1:0] ADDR_CLR = 16'h0004
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IRQ-1:0]  req_set,
    input  logic [N_IRQ-1:0]  req_clr,
    output logic              busy,
    output logic              err,
    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic [1:0]        ahblm_htrans,
    output logic              ahblm_hwrite,
    output logic [2:0]        ahblm_hsize,
    input  logic              ahblm_hready,
    output logic [31:0]       ahblm_hwdata,
    input  logic              ahblm_hresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t              state_r, state_s;
    logic [N_IRQ-1:0]    set_pend_r, set_pend_s;
    logic [N_IRQ-1:0]    clr_pend_r, clr_pend_s;
    logic [N_IRQ-1:0]    set_base_s, clr_base_s;
    logic [N_IRQ-1:0]    wdata_r, wdata_s;
    logic                is_clr_r, is_clr_s;
    logic [W_ADDR-1:0]   haddr_r, haddr_s;
    logic [1:0]          htrans_r, htrans_s;
    logic                hwrite_r, hwrite_s;
    logic [31:0]         hwdata_r, hwdata_s;
    logic                busy_r, busy_s;
    logic                err_r, err_s;

    // Next-state, request merging and next values of the registered bus outputs.
    always_comb begin
        state_s    = state_r;
        wdata_s    = wdata_r;
        is_clr_s   = is_clr_r;
        err_s      = 1'b0;
        set_base_s = set_pend_r;
        clr_base_s = clr_pend_r;

        case (state_r)
            ST_IDLE: begin
                // Clear goes first so that a set posted after it ends up winning.
                if (|clr_pend_r) begin
                    is_clr_s   = 1'b1;
                    wdata_s    = clr_pend_r;
                    clr_base_s = {N_IRQ{1'b0}};
                    state_s    = ST_ADDR;
                end else if (|set_pend_r) begin
                    is_clr_s   = 1'b0;
                    wdata_s    = set_pend_r;
                    set_base_s = {N_IRQ{1'b0}};
                    state_s    = ST_ADDR;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (ahblm_hready) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                // An errored write is not retried; its snapshot is simply dropped.
                if (ahblm_hready) begin
                    state_s = ST_IDLE;
                    err_s   = ahblm_hresp;
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Merge this cycle's requests after the snapshot is removed. The last
        // request for a bit wins. Within one cycle, set beats clear.
        set_pend_s = (set_base_s & ~req_clr) | req_set;
        clr_pend_s = (clr_base_s | req_clr) & ~req_set;

        htrans_s = (state_s == ST_ADDR) ? 2'b10 : 2'b00;
        hwrite_s = (state_s == ST_ADDR);

        if (state_s == ST_ADDR) begin
            haddr_s = is_clr_s ? ADDR_CLR : ADDR_SET;
        end else begin
            haddr_s = haddr_r;
        end

        hwdata_s = 32'h0000_0000;
        if (state_s == ST_DATA) begin
            hwdata_s[N_IRQ-1:0] = wdata_s;
        end else begin
            hwdata_s = 32'h0000_0000;
        end

        busy_s = (|set_pend_s) || (|clr_pend_s) || (state_s != ST_IDLE);
    end

    // FSM state, pending vectors, snapshot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            set_pend_r <= {N_IRQ{1'b0}};
            clr_pend_r <= {N_IRQ{1'b0}};
            wdata_r    <= {N_IRQ{1'b0}};
            is_clr_r   <= 1'b0;
            haddr_r    <= ADDR_SET;
            htrans_r   <= 2'b00;
            hwrite_r   <= 1'b0;
            hwdata_r   <= 32'h0000_0000;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            set_pend_r <= set_pend_s;
            clr_pend_r <= clr_pend_s;
            wdata_r    <= wdata_s;
            is_clr_r   <= is_clr_s;
            haddr_r    <= haddr_s;
            htrans_r   <= htrans_s;
            hwrite_r   <= hwrite_s;
            hwdata_r   <= hwdata_s;
            busy_r     <= busy_s;
            err_r      <= err_s;
        end
    end

    assign ahblm_haddr  = haddr_r;
    assign ahblm_htrans = htrans_r;
    assign ahblm_hwrite = hwrite_r;
    assign ahblm_hsize  = 3'b010;
    assign ahblm_hwdata = hwdata_r;
    assign busy         = busy_r;
    assign err          = err_r;

endmodule

// File: tb/tb_ipc_doorbell_master.sv
// Testbench for ipc_doorbell_master: directed scenarios plus a randomized run,
// each checked against a transaction-level doorbell model.
module tb_ipc_doorbell_master;

    localparam int          N_IRQ = 2;
    localparam logic [15:0] A_SET = 16'h0000;
    localparam logic [15:0] A_CLR = 16'h0004;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_set, req_clr;
    logic        busy, err;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic [31:0] hwdata;
    logic        hresp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ipc_doorbell_master #(.N_IRQ(N_IRQ), .W_ADDR(16), .ADDR_SET(A_SET), .ADDR_CLR(A_CLR)) dut (
        .clk(clk), .rst_n(rst_n), .req_set(req_set), .req_clr(req_clr),
        .busy(busy), .err(err), .ahblm_haddr(haddr), .ahblm_htrans(htrans),
        .ahblm_hwrite(hwrite), .ahblm_hsize(hsize), .ahblm_hready(hready),
        .ahblm_hwdata(hwdata), .ahblm_hresp(hresp)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    // Model: per-bit latest request (0 none, 1 set, 2 clr), writes predicted
    // at snapshot time, and writes observed completing on the bus.
    int         kind [N_IRQ];
    wr_t        exp_q[$];
    wr_t        act_q[$];
    bit         free_m, addr_pend_m, in_data_m;
    bit         exp_busy, exp_err;
    logic [1:0] exp_htrans;
    logic [15:0] cur_addr;

    int checks   = 0;
    int failures = 0;

    task automatic model_reset();
        for (int i = 0; i < N_IRQ; i++) kind[i] = 0;
        exp_q.delete();
        act_q.delete();
        free_m = 1'b1; addr_pend_m = 1'b0; in_data_m = 1'b0;
        exp_busy = 1'b0; exp_err = 1'b0; exp_htrans = 2'b00;
        cur_addr = 16'h0000;
    endtask

    // Advance one clock: the model consumes the inputs in force at this edge.
    task automatic step();
        bit          done;
        logic [31:0] s_bits, c_bits;
        wr_t         w;
        @(negedge clk);
        done    = 1'b0;
        exp_err = 1'b0;
        if (in_data_m && hready) begin
            w.addr = cur_addr; w.data = hwdata;
            act_q.push_back(w);
            in_data_m = 1'b0; done = 1'b1; exp_err = hresp;
        end
        if (addr_pend_m && hready) begin
            addr_pend_m = 1'b0; in_data_m = 1'b1; cur_addr = haddr;
        end
        if (free_m) begin
            s_bits = 32'h0; c_bits = 32'h0;
            for (int i = 0; i < N_IRQ; i++) begin
                if (kind[i] == 2) c_bits[i] = 1'b1;
                if (kind[i] == 1) s_bits[i] = 1'b1;
            end
            if (c_bits != 32'h0) begin
                w.addr = A_CLR; w.data = c_bits; exp_q.push_back(w);
                for (int i = 0; i < N_IRQ; i++) if (kind[i] == 2) kind[i] = 0;
                free_m = 1'b0; addr_pend_m = 1'b1;
            end else if (s_bits != 32'h0) begin
                w.addr = A_SET; w.data = s_bits; exp_q.push_back(w);
                for (int i = 0; i < N_IRQ; i++) if (kind[i] == 1) kind[i] = 0;
                free_m = 1'b0; addr_pend_m = 1'b1;
            end
        end
        for (int i = 0; i < N_IRQ; i++) begin
            if (req_set[i]) kind[i] = 1;
            else if (req_clr[i]) kind[i] = 2;
        end
        if (done) free_m = 1'b1;
        exp_htrans = addr_pend_m ? 2'b10 : 2'b00;
        exp_busy   = !free_m;
        for (int i = 0; i < N_IRQ; i++) if (kind[i] != 0) exp_busy = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_set = 2'b00; req_clr = 2'b00; hready = 1'b1; hresp = 1'b0;
        model_reset();
        #12;
        checks += 7;
        if (htrans !== 2'b00)  begin failures++; $display("FAIL reset_htrans got=%b exp=00", htrans); end
        if (haddr !== A_SET)   begin failures++; $display("FAIL reset_haddr got=%h exp=%h", haddr, A_SET); end
        if (hwrite !== 1'b0)   begin failures++; $display("FAIL reset_hwrite got=%b exp=0", hwrite); end
        if (hwdata !== 32'h0)  begin failures++; $display("FAIL reset_hwdata got=%h exp=0", hwdata); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (err !== 1'b0)      begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        if (hsize !== 3'b010)  begin failures++; $display("FAIL reset_hsize got=%b exp=010", hsize); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_set();
        act_q.delete(); exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            req_set = (c == 0) ? 2'b01 : 2'b00;
            step();
            req_set = 2'b00;
            checks += 3;
            if (htrans !== exp_htrans) begin failures++; $display("FAIL single_htrans c=%0d got=%b exp=%b", c, htrans, exp_htrans); end
            if (busy !== exp_busy)     begin failures++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
            if (err !== exp_err)       begin failures++; $display("FAIL single_err c=%0d got=%b exp=%b", c, err, exp_err); end
            if (c == 1) begin
                checks += 4;
                if (htrans !== 2'b10)  begin failures++; $display("FAIL single_nonseq got=%b exp=10", htrans); end
                if (haddr !== A_SET)   begin failures++; $display("FAIL single_haddr got=%h exp=%h", haddr, A_SET); end
                if (hwrite !== 1'b1)   begin failures++; $display("FAIL single_hwrite got=%b exp=1", hwrite); end
                if (hsize !== 3'b010)  begin failures++; $display("FAIL single_hsize got=%b exp=010", hsize); end
            end
            if (c == 2) begin
                checks += 2;
                if (htrans !== 2'b00)        begin failures++; $display("FAIL single_data_htrans got=%b exp=00", htrans); end
                if (hwdata !== 32'h00000001) begin failures++; $display("FAIL single_hwdata got=%h exp=1", hwdata); end
            end
            if (c == 3) begin
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
            end
        end
        checks++;
        if (act_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", act_q.size()); end
        else begin
            checks++;
            if (act_q[0] !== {A_SET, 32'h1}) begin failures++; $display("FAIL single_write got=%h exp=%h", act_q[0], {A_SET, 32'h1}); end
        end
    endtask

    task automatic test_set_clr_same();
        logic [47:0] want [2];
        want[0] = {A_CLR, 32'h2};
        want[1] = {A_SET, 32'h1};
        act_q.delete(); exp_q.delete();
        for (int c = 0; c < 12; c++) begin
            req_set = (c == 0) ? 2'b01 : 2'b00;
            req_clr = (c == 0) ? 2'b10 : 2'b00;
            step();
            req_set = 2'b00; req_clr = 2'b00;
            checks += 2;
            if (htrans !== exp_htrans) begin failures++; $display("FAIL same_htrans c=%0d got=%b exp=%b", c, htrans, exp_htrans); end
            if (busy !== exp_busy)     begin failures++; $display("FAIL same_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
        end
        checks++;
        if (act_q.size() != 2) begin failures++; $display("FAIL same_count got=%0d exp=2", act_q.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_q[i] !== want[i]) begin failures++; $display("FAIL same_write%0d got=%h exp=%h", i, act_q[i], want[i]); end
            end
        end
    endtask

    task automatic test_wait_states();
        act_q.delete(); exp_q.delete();
        for (int c = 0; c < 11; c++) begin
            req_set = (c == 0) ? 2'b10 : 2'b00;
            hready  = (c >= 2 && c <= 4) || (c == 6) || (c == 7) ? 1'b0 : 1'b1;
            step();
            req_set = 2'b00; hready = 1'b1;
            checks += 2;
            if (htrans !== exp_htrans) begin failures++; $display("FAIL wait_htrans c=%0d got=%b exp=%b", c, htrans, exp_htrans); end
            if (busy !== exp_busy)     begin failures++; $display("FAIL wait_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
            if (c >= 1 && c <= 4) begin
                checks += 2;
                if (htrans !== 2'b10) begin failures++; $display("FAIL wait_addr_htrans c=%0d got=%b exp=10", c, htrans); end
                if (haddr !== A_SET)  begin failures++; $display("FAIL wait_addr_haddr c=%0d got=%h exp=%h", c, haddr, A_SET); end
            end
            if (c >= 5 && c <= 7) begin
                checks += 2;
                if (hwdata !== 32'h2) begin failures++; $display("FAIL wait_hwdata c=%0d got=%h exp=2", c, hwdata); end
                if (htrans !== 2'b00) begin failures++; $display("FAIL wait_data_htrans c=%0d got=%b exp=00", c, htrans); end
            end
        end
        checks++;
        if (act_q.size() != 1) begin failures++; $display("FAIL wait_count got=%0d exp=1", act_q.size()); end
        else begin
            checks++;
            if (act_q[0] !== {A_SET, 32'h2}) begin failures++; $display("FAIL wait_write got=%h exp=%h", act_q[0], {A_SET, 32'h2}); end
        end
    endtask

    task automatic test_error();
        logic [47:0] want [2];
        want[0] = {A_SET, 32'h1};
        want[1] = {A_SET, 32'h2};
        act_q.delete(); exp_q.delete();
        for (int c = 0; c < 12; c++) begin
            req_set = (c == 0) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
            hresp   = (c == 3 || c == 4) ? 1'b1 : 1'b0;
            hready  = (c == 3) ? 1'b0 : 1'b1;
            step();
            req_set = 2'b00; hresp = 1'b0; hready = 1'b1;
            checks += 3;
            if (htrans !== exp_htrans) begin failures++; $display("FAIL err_htrans c=%0d got=%b exp=%b", c, htrans, exp_htrans); end
            if (busy !== exp_busy)     begin failures++; $display("FAIL err_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
            if (err !== exp_err)       begin failures++; $display("FAIL err_err c=%0d got=%b exp=%b", c, err, exp_err); end
            if (c == 3 || c == 4) begin
                checks += 2;
                if (htrans !== 2'b00) begin failures++; $display("FAIL err_idle c=%0d got=%b exp=00", c, htrans); end
                if (err !== (c == 4)) begin failures++; $display("FAIL err_pulse c=%0d got=%b exp=%b", c, err, (c == 4)); end
            end
            if (c == 5) begin
                checks++;
                if (err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", err); end
            end
        end
        checks++;
        if (act_q.size() != 2) begin failures++; $display("FAIL err_count got=%0d exp=2", act_q.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_q[i] !== want[i]) begin failures++; $display("FAIL err_write%0d got=%h exp=%h", i, act_q[i], want[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] want [4];
        want[0] = {A_SET, 32'h1};
        want[1] = {A_SET, 32'h2};
        want[2] = {A_SET, 32'h1};
        want[3] = {A_SET, 32'h1};
        act_q.delete(); exp_q.delete();
        for (int c = 0; c < 17; c++) begin
            req_set = (c == 0 || c == 7 || c == 10) ? 2'b01 : (c == 3) ? 2'b10 : 2'b00;
            req_clr = (c == 9) ? 2'b01 : 2'b00;
            step();
            req_set = 2'b00; req_clr = 2'b00;
            checks += 2;
            if (htrans !== exp_htrans) begin failures++; $display("FAIL b2b_htrans c=%0d got=%b exp=%b", c, htrans, exp_htrans); end
            if (busy !== exp_busy)     begin failures++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
        end
        checks++;
        if (act_q.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", act_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_q[i] !== want[i]) begin failures++; $display("FAIL b2b_write%0d got=%h exp=%h", i, act_q[i], want[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        act_q.delete(); exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            req_set = (c == 0) ? 2'b01 : 2'b00;
            req_clr = (c == 2) ? 2'b10 : 2'b00;
            step();
            req_set = 2'b00; req_clr = 2'b00;
        end
        checks += 2;
        if (busy !== 1'b1)    begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        if (hwdata !== 32'h1) begin failures++; $display("FAIL rstmid_hwdata_before got=%h exp=1", hwdata); end
        rst_n = 1'b0;
        #2;
        checks += 3;
        if (htrans !== 2'b00) begin failures++; $display("FAIL rstmid_htrans got=%b exp=00", htrans); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        if (hwdata !== 32'h0) begin failures++; $display("FAIL rstmid_hwdata got=%h exp=0", hwdata); end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 12; c++) begin
            req_set = (c == 6) ? 2'b01 : 2'b00;
            step();
            req_set = 2'b00;
            checks += 2;
            if (htrans !== exp_htrans) begin failures++; $display("FAIL rstmid_post_htrans c=%0d got=%b exp=%b", c, htrans, exp_htrans); end
            if (busy !== exp_busy)     begin failures++; $display("FAIL rstmid_post_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
        end
        checks++;
        if (act_q.size() != 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", act_q.size()); end
        else begin
            checks++;
            if (act_q[0] !== {A_SET, 32'h1}) begin failures++; $display("FAIL rstmid_write got=%h exp=%h", act_q[0], {A_SET, 32'h1}); end
        end
    endtask

    task automatic test_random();
        int k;
        act_q.delete(); exp_q.delete();
        for (int c = 0; c < 800; c++) begin
            req_set = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            req_clr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            hready  = ($urandom_range(0, 3) != 0);
            step();
            checks += 3;
            if (htrans !== exp_htrans) begin failures++; $display("FAIL rand_htrans c=%0d got=%b exp=%b", c, htrans, exp_htrans); end
            if (busy !== exp_busy)     begin failures++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
            if (hwrite !== (exp_htrans == 2'b10)) begin failures++; $display("FAIL rand_hwrite c=%0d got=%b exp=%b", c, hwrite, (exp_htrans == 2'b10)); end
        end
        req_set = 2'b00; req_clr = 2'b00; hready = 1'b1;
        k = 0;
        while ((busy || exp_busy) && k < 40) begin
            step();
            k++;
        end
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL rand_drain busy got=%b exp=0", busy); end
        if (act_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_write%0d got=%h exp=%h", i, act_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_set_clr_same();
        test_wait_states();
        test_error();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
